// File: rtl/mem_arb.sv
// Two-master arbiter in front of a single-port RAM: core (m0) and debug/loader (m1).
// m0 has priority. m1 is forced a grant after STARVE_LIM wait cycles and can lock ownership.
module mem_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [DW/8-1:0] m0_wem,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic            m1_lock,
    input  logic [DW/8-1:0] m1_wem,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,

    output logic            ram_cs,
    output logic            ram_we,
    output logic [DW/8-1:0] ram_wem,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata,

    output logic            hold_flag_o
);

    // state | meaning
    // IDLE  | no access granted last cycle
    // OWN0  | m0 won last cycle
    // OWN1  | m1 won last cycle (m1_lock may keep it)
    // The same encoding tracks which master owes a read return (IDLE = none).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    owner_t     owner_q, owner_d;
    owner_t     rd_owner_q, rd_owner_d;
    owner_t     win;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk) begin
        if (rstn) begin
            owner_q    <= IDLE;
            rd_owner_q <= IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            owner_q    <= owner_d;
            rd_owner_q <= rd_owner_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        win = IDLE;
        if (owner_q == OWN1 && m1_lock && m1_req)
            win = OWN1;
        else if (m1_req && wait_cnt_q == LIM)
            win = OWN1;
        else if (m0_req)
            win = OWN0;
        else if (m1_req)
            win = OWN1;
        // Reset gates the winner so every grant and RAM strobe is held low.
        if (rstn)
            win = IDLE;
    end

    always_comb begin
        owner_d    = win;
        rd_owner_d = IDLE;
        wait_cnt_d = 4'd0;

        m0_gnt    = (win == OWN0);
        m1_gnt    = (win == OWN1);
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_wem   = '0;
        ram_addr  = '0;
        ram_wdata = '0;

        unique case (win)
            OWN0: begin
                ram_cs    = 1'b1;
                ram_we    = m0_we;
                ram_wem   = m0_wem;
                ram_addr  = m0_addr;
                ram_wdata = m0_wdata;
                if (!m0_we)
                    rd_owner_d = OWN0;
            end
            OWN1: begin
                ram_cs    = 1'b1;
                ram_we    = m1_we;
                ram_wem   = m1_wem;
                ram_addr  = m1_addr;
                ram_wdata = m1_wdata;
                if (!m1_we)
                    rd_owner_d = OWN1;
            end
            default: ;
        endcase

        if (m1_req && win != OWN1)
            wait_cnt_d = (wait_cnt_q >= LIM) ? LIM : wait_cnt_q + 4'd1;

        m0_rvalid   = !rstn && rd_owner_q == OWN0;
        m1_rvalid   = !rstn && rd_owner_q == OWN1;
        m0_rdata    = m0_rvalid ? ram_rdata : '0;
        m1_rdata    = m1_rvalid ? ram_rdata : '0;
        hold_flag_o = !rstn && m0_req && !m0_gnt;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios with literal expectations, then random traffic
// checked every cycle against a rule-level arbitration model.
module tb_mem_arb;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic            m0_req, m0_we;
    logic [DW/8-1:0] m0_wem;
    logic [AW-1:0]   m0_addr;
    logic [DW-1:0]   m0_wdata;
    logic            m0_gnt, m0_rvalid;
    logic [DW-1:0]   m0_rdata;
    logic            m1_req, m1_we, m1_lock;
    logic [DW/8-1:0] m1_wem;
    logic [AW-1:0]   m1_addr;
    logic [DW-1:0]   m1_wdata;
    logic            m1_gnt, m1_rvalid;
    logic [DW-1:0]   m1_rdata;
    logic            ram_cs, ram_we;
    logic [DW/8-1:0] ram_wem;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;
    logic            hold_flag_o;

    int checks   = 0;
    int failures = 0;

    mem_arb #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_wem(m0_wem), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_wem(m1_wem),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .hold_flag_o(hold_flag_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: owner/read-owner as 0=none, 1=m0, 2=m1; wait is a plain integer.
    int m_own  = 0;
    int m_wait = 0;
    int m_rd   = 0;

    always @(negedge clk) begin
        int w;
        logic e_cs, e_we;
        logic [DW/8-1:0] e_wem;
        logic [AW-1:0]   e_addr;
        logic [DW-1:0]   e_wdata;
        logic e_rv0, e_rv1;

        w = 0;
        if (!rstn) begin
            if (m_own == 2 && m1_lock && m1_req) w = 2;
            else if (m1_req && m_wait == LIM)    w = 2;
            else if (m0_req)                     w = 1;
            else if (m1_req)                     w = 2;
        end
        e_cs = (w != 0);
        e_we = (w == 1) ? m0_we : (w == 2) ? m1_we : 1'b0;
        e_wem = (w == 1) ? m0_wem : (w == 2) ? m1_wem : '0;
        e_addr = (w == 1) ? m0_addr : (w == 2) ? m1_addr : '0;
        e_wdata = (w == 1) ? m0_wdata : (w == 2) ? m1_wdata : '0;
        e_rv0 = !rstn && m_rd == 1;
        e_rv1 = !rstn && m_rd == 2;

        chk("m_gnt", {m0_gnt, m1_gnt}, {62'd0, w == 1, w == 2});
        chk("m_ram_ctl", {ram_cs, ram_we, ram_wem}, {e_cs, e_we, e_wem});
        chk("m_ram_addr", ram_addr, e_addr);
        chk("m_ram_wdata", ram_wdata, e_wdata);
        chk("m_rvalid", {m0_rvalid, m1_rvalid}, {e_rv0, e_rv1});
        chk("m_m0_rdata", m0_rdata, e_rv0 ? ram_rdata : '0);
        chk("m_m1_rdata", m1_rdata, e_rv1 ? ram_rdata : '0);
        chk("m_hold", hold_flag_o, !rstn && m0_req && w != 1);

        if (rstn) begin
            m_own = 0; m_wait = 0; m_rd = 0;
        end else begin
            m_rd   = (w == 1 && !m0_we) ? 1 : (w == 2 && !m1_we) ? 2 : 0;
            m_wait = (!m1_req || w == 2) ? 0 : ((m_wait + 1 > LIM) ? LIM : m_wait + 1);
            m_own  = w;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        m0_req = 0; m0_we = 0; m0_wem = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_wem = '0; m1_addr = '0; m1_wdata = '0;
    endtask

    initial begin
        rstn = 1'b1;
        ram_rdata = '0;
        clear_in();
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("rst_gnt", {m0_gnt, m1_gnt, ram_cs}, 64'd0);
        chk("rst_hold", hold_flag_o, 1'b0);
        repeat (2) next_cyc();
        clear_in();
        rstn = 1'b0;

        // m0 single read
        m0_req = 1; m0_addr = 32'h10;
        @(negedge clk);
        chk("rd_gnt", {m0_gnt, ram_cs, ram_we}, 64'b110);
        chk("rd_addr", ram_addr, 64'h10);
        next_cyc();
        clear_in(); ram_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rd_rvalid", m0_rvalid, 1'b1);
        chk("rd_rdata", m0_rdata, 64'h1234_5678);
        next_cyc();

        // m0 masked write
        m0_req = 1; m0_we = 1; m0_wem = 4'b0011; m0_wdata = 32'hDEAD_BEEF; m0_addr = 32'h44;
        @(negedge clk);
        chk("wr_ctl", {ram_cs, ram_we, ram_wem}, {58'd0, 6'b11_0011});
        chk("wr_data", ram_wdata, 64'hDEAD_BEEF);
        next_cyc();
        clear_in();
        @(negedge clk);
        chk("wr_no_rvalid", {m0_rvalid, m1_rvalid}, 64'd0);
        next_cyc();

        // starvation pattern
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("starve_m1", m1_gnt, (i % 5) == 4);
            chk("starve_m0", m0_gnt, (i % 5) != 4);
            chk("starve_hold", hold_flag_o, (i % 5) == 4);
            next_cyc();
        end
        clear_in();
        next_cyc();

        // m1 lock
        m1_req = 1; m1_lock = 1;
        @(negedge clk);
        chk("lock_first", m1_gnt, 1'b1);
        next_cyc();
        m0_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lock_keep", {m0_gnt, m1_gnt, hold_flag_o}, 64'b011);
            next_cyc();
        end
        m1_lock = 0;
        @(negedge clk);
        chk("lock_drop", {m0_gnt, m1_gnt}, 64'b10);
        next_cyc();
        clear_in();
        next_cyc();

        // reset right after an m1 read grant
        m1_req = 1; m1_addr = 32'h80;
        @(negedge clk);
        chk("rst_m1_gnt", m1_gnt, 1'b1);
        next_cyc();
        rstn = 1; m0_req = 1; ram_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("rst_suppress", {m1_rvalid, m1_rdata, m0_gnt, ram_cs, hold_flag_o}, 64'd0);
        next_cyc();
        rstn = 0; m1_req = 0;
        @(negedge clk);
        chk("rst_release", {m0_gnt, m1_rvalid}, 64'b10);
        next_cyc();
        clear_in();
        next_cyc();

        // master switch: m0 read then m1 read
        m0_req = 1; m0_addr = 32'h20;
        next_cyc();
        clear_in(); m1_req = 1; m1_addr = 32'h30; ram_rdata = 32'hAAAA_AAAA;
        @(negedge clk);
        chk("sw_c2", {m0_rvalid, m1_gnt}, 64'b11);
        chk("sw_m0_rdata", m0_rdata, 64'hAAAA_AAAA);
        next_cyc();
        clear_in(); ram_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("sw_c3", {m0_rvalid, m1_rvalid}, 64'b01);
        chk("sw_m1_rdata", m1_rdata, 64'h5555_5555);
        chk("sw_m0_zero", m0_rdata, 64'd0);
        next_cyc();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rstn     = ($urandom_range(0, 99) == 0);
            m0_req   = ($urandom_range(0, 2) != 0);
            m0_we    = $urandom_range(0, 1);
            m0_wem   = 4'($urandom);
            m0_addr  = $urandom;
            m0_wdata = $urandom;
            m1_req   = ($urandom_range(0, 2) != 0);
            m1_we    = $urandom_range(0, 1);
            m1_lock  = ($urandom_range(0, 3) != 0);
            m1_wem   = 4'($urandom);
            m1_addr  = $urandom;
            m1_wdata = $urandom;
            ram_rdata = $urandom;
            next_cyc();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL take parameter AW, default 32, the memory address width.
REQ-002 SHALL take parameter DW, default 32, the data width; write mask width is DW/8.
REQ-003 SHALL take parameter STARVE_LIM, default 4, legal range 1..15: wait cycles before m1 is forced a grant.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1, reset, synchronous and active-high (1 = reset), per this block's fixed convention.
REQ-006 SHALL have ports m0_req/m0_we (input, 1), m0_wem (input, DW/8), m0_addr (input, AW), m0_wdata (input, DW): core load/store requester.
REQ-007 SHALL have ports m0_gnt (output, 1), m0_rvalid (output, 1), m0_rdata (output, DW): core grant and read return.
REQ-008 SHALL have ports m1_req/m1_we/m1_lock (input, 1), m1_wem, m1_addr, m1_wdata (input, as m0): debug/loader requester; m1_lock holds ownership.
REQ-009 SHALL have ports m1_gnt, m1_rvalid (output, 1), m1_rdata (output, DW).
REQ-010 SHALL have ports ram_cs, ram_we (output, 1), ram_wem (output, DW/8), ram_addr (output, AW), ram_wdata (output, DW), ram_rdata (input, DW): single-port RAM, read data valid 1 cycle after cs & !we.
REQ-011 SHALL have port hold_flag_o, output, 1: pipeline stall request to ctrl.

Function
REQ-012 SHALL keep state OWNER in {IDLE, OWN0, OWN1}, equal to the previous cycle's winner, or IDLE if there was none.
REQ-013 SHALL pick the winner combinationally each cycle, first match wins: (a) OWNER=OWN1 & m1_lock & m1_req -> m1; (b) m1_req & wait_cnt==STARVE_LIM -> m1; (c) m0_req -> m0; (d) m1_req -> m1; else none.
REQ-014 SHALL assert the winner's gnt in the same cycle as its req (zero-latency grant), with at most one gnt high per cycle.
REQ-015 SHALL drive ram_cs=1 and mux the winner's we/wem/addr/wdata onto ram_* in the grant cycle; with no winner, all ram_* outputs SHALL be 0.
REQ-016 SHALL maintain a 4-bit wait_cnt: +1 when m1_req & !m1_gnt, saturating at STARVE_LIM; cleared to 0 when m1_gnt or !m1_req.
REQ-017 SHALL register rd_owner (none/m0/m1) each cycle, set to the winner when the granted access is a read, else none.
REQ-018 SHALL assert mX_rvalid=1 and mX_rdata=ram_rdata exactly one cycle after mX's read grant; the non-owner's rvalid=0 and rdata=0.
REQ-019 SHALL perform writes in the grant cycle with no rvalid response.
REQ-020 SHALL drive hold_flag_o = m0_req & !m0_gnt combinationally.
REQ-021 SHALL ignore m1_lock unless OWNER=OWN1; dropping m1_lock with m1_req held SHALL return m1 to rule (d) priority that cycle.
REQ-022 SHALL support back-to-back grants to either master every cycle, and a read grant concurrent with the previous read's rvalid.
REQ-023 SHALL, when rules (a) and (b) both match, grant m1 once; wait_cnt clears.
REQ-024 SHALL, on master switch (m0 read then m1 read), return the m0 rvalid and the m1 grant in the same cycle without stall.
REQ-025 SHALL treat req inputs as level; a master deasserting req loses nothing already granted.

Reset
REQ-026 SHALL, while rstn=1 at a clock edge, set OWNER=IDLE, wait_cnt=0, rd_owner=none.
REQ-027 SHALL, while rstn=1, force all outputs to 0 (gnt, rvalid, rdata, ram_*, hold_flag_o) regardless of inputs.
REQ-028 SHALL suppress an rvalid pending from a read granted in the cycle before reset asserts.
REQ-029 SHALL allow arbitration in the first cycle after rstn falls, with m0 priority and wait_cnt=0.

Verification
REQ-030 SHALL cover: m0 read addr 0x10 alone -> m0_gnt same cycle, ram_cs=1, ram_we=0; next cycle m0_rvalid=1, m0_rdata=ram_rdata.
REQ-031 SHALL cover: m0_req and m1_req held continuously, STARVE_LIM=4 -> m0 granted 4 cycles, m1 on the 5th, pattern repeats; hold_flag_o=1 only on m1 cycles.
REQ-032 SHALL cover: m1 granted with m1_lock=1, m0_req raised -> m1 keeps grant for 3 locked cycles, hold_flag_o=1; lock drop -> m0 granted the next cycle.
REQ-033 SHALL cover: m0 write wem=4'b0011 data 0xDEADBEEF -> ram_we=1, ram_wem=0011, ram_wdata=0xDEADBEEF, no rvalid follows.
REQ-034 SHALL cover: m1 read granted, rstn=1 next cycle -> m1_rvalid=0, all outputs 0; after release m0 read granted immediately.
REQ-035 SHALL cover: m0 read then m1 read on consecutive cycles -> m0_rvalid and m1_gnt both high in cycle 2; m1_rvalid in cycle 3, m0_rdata=0.
